fifo_write_arbiter: RTL

//  Round-robin arbiter sharing the single write port of one FIFO instance among REQS producers.

---
 rtl/fifo_write_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among REQS valid/ready producers, BURST words per grant.
// Optional macro FIFO_ARB_PRIO_EN: requester 0 always wins arbitration when the port is idle.
module fifo_write_arbiter #(
    parameter int REQS  = 4,
    parameter int BITS  = 32,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REQS-1:0]      req_valid,
    input  logic [REQS*BITS-1:0] req_data,
    output logic [REQS-1:0]      req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_write_en,
    output logic [BITS-1:0]      fifo_data,
    output logic [REQS-1:0]      grant,
    output logic                 busy
);
    localparam int IW = (REQS > 1) ? $clog2(REQS) : 1;
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] last, last_n;
    logic [BW-1:0] beat, beat_n;
    logic [IW-1:0] pick, cand;
    logic          found;
    logic          xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= '0;
            last  <= IW'(REQS - 1);
            beat  <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            beat  <= beat_n;
        end
    end

    // Scan upward from the slot after the previous winner, wrapping at REQS.
    always_comb begin
        pick  = last;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= REQS; k++) begin
            cand = IW'((int'(last) + k) % REQS);
            if (!found && req_valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
`ifdef FIFO_ARB_PRIO_EN
        if (req_valid[0]) begin
            pick = '0;
        end
`else
`endif
    end

    assign xfer = (state == BUSY) && req_valid[owner] && !fifo_full;

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        beat_n  = beat;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_n = BUSY;
                    owner_n = pick;
                    last_n  = pick;
                    beat_n  = '0;
                end
            end
            BUSY: begin
                if (!req_valid[owner]) begin
                    state_n = IDLE;
                end else if (xfer) begin
                    if (beat == BW'(BURST - 1)) begin
                        state_n = IDLE;
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Port outputs only exist while a producer owns the port.
    always_comb begin
        req_ready     = '0;
        grant         = '0;
        fifo_write_en = 1'b0;
        fifo_data     = '0;
        busy          = (state == BUSY);
        if (state == BUSY) begin
            grant[owner]     = 1'b1;
            req_ready[owner] = !fifo_full;
            fifo_write_en    = xfer;
            fifo_data        = req_data[int'(owner)*BITS +: BITS];
        end
    end
endmodule
